spike_filter_array: RTL and testbench

- Stage directly downstream of the tag/count input path and upstream of the filter-output serializer.
- Consumes (tag, ct) spike-count channel words and holds one exponentially-decaying accumulator per filter.
- Once per FPGA time unit, sweeps all active filters, emits each filter's state on a filter-output channel, then applies decay.
- Configuration comes from the spike-filter register bundle (filts_used, increment_constant, decay_constant).

---
 rtl/spike_filter_pkg.sv | 59 +++++
 rtl/spike_filter_array_if.sv | 44 ++++
 rtl/spike_filter_state_ram.sv | 46 ++++
 rtl/spike_filter_array.sv | 231 +++++++++++++++++++++++
 tb/tb_spike_filter_array.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/spike_filter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spike_filter_pkg
// Description : Shared constants, FSM state encodings and arithmetic helpers
//               for the spike filter array. The helpers work on 64-bit
//               containers so they serve any width set with
//               NSTATE + NCT <= 63 and 2*NSTATE <= 64.
// Revision    : 1.0 - initial release
// ============================================================================
package spike_filter_pkg;

    // Default widths
    localparam int c_NFILTS = 10;   // filter index width
    localparam int c_NSTATE = 27;   // accumulator width (unsigned)
    localparam int c_NTAG   = 11;   // input tag width
    localparam int c_NCT    = 9;    // input spike-count width

    // FSM state encodings
    typedef logic [2:0] fsm_state_t;
    localparam fsm_state_t c_ST_CLEAR     = 3'd0;
    localparam fsm_state_t c_ST_IDLE      = 3'd1;
    localparam fsm_state_t c_ST_UPD       = 3'd2;
    localparam fsm_state_t c_ST_SWEEP_RD  = 3'd3;
    localparam fsm_state_t c_ST_SWEEP_OUT = 3'd4;

    // state + incr*ct, clamped to the largest nstate-bit value.
    // The product and sum are formed wide so nothing wraps before the clamp.
    function automatic logic [63:0] f_sat_update(
        input logic [63:0] state,
        input logic [63:0] incr,
        input logic [63:0] ct,
        input int unsigned nstate
    );
        logic [63:0] v_max;
        logic [63:0] v_prod;
        logic [64:0] v_sum;
        v_max  = (64'd1 << nstate) - 64'd1;
        v_prod = incr * ct;
        v_sum  = {1'b0, state} + {1'b0, v_prod};
        if (v_sum > {1'b0, v_max}) begin
            return v_max;
        end
        return v_sum[63:0];
    endfunction

    // (state * decay) >> nstate, i.e. multiply by a Q0.nstate fraction,
    // truncating toward zero.
    function automatic logic [63:0] f_decay(
        input logic [63:0] state,
        input logic [63:0] decay,
        input int unsigned nstate
    );
        logic [63:0] v_prod;
        v_prod = state * decay;
        return v_prod >> nstate;
    endfunction

endpackage : spike_filter_pkg
`default_nettype wire

// File: rtl/spike_filter_array_if.sv
`default_nettype none
// ============================================================================
// Module      : spike_filter_array_if
// Description : Spike-count input channel and filter-output channel of the
//               spike filter array, both valid/acknowledge handshakes.
//               Ports (signals):
//                 in_tag, in_ct, in_v -> in_a         : spike-count channel
//                 out_filt_idx, out_filt_state, out_v -> out_a : filter output
//               master = traffic source/sink around the array,
//               slave  = the array itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface spike_filter_array_if
    import spike_filter_pkg::*;
#(
    parameter int NFILTS = c_NFILTS,
    parameter int NSTATE = c_NSTATE,
    parameter int NTAG   = c_NTAG,
    parameter int NCT    = c_NCT
);
    logic [NTAG-1:0]   in_tag;
    logic [NCT-1:0]    in_ct;
    logic              in_v;
    logic              in_a;
    logic [NFILTS-1:0] out_filt_idx;
    logic [NSTATE-1:0] out_filt_state;
    logic              out_v;
    logic              out_a;

    modport master (
        output in_tag, in_ct, in_v,
        input  in_a,
        input  out_filt_idx, out_filt_state, out_v,
        output out_a
    );

    modport slave (
        input  in_tag, in_ct, in_v,
        output in_a,
        output out_filt_idx, out_filt_state, out_v,
        input  out_a
    );
endinterface : spike_filter_array_if
`default_nettype wire

// File: rtl/spike_filter_state_ram.sv
`default_nettype none
// ============================================================================
// Module      : spike_filter_state_ram
// Description : 1R1W filter-state memory, 2**NFILTS x NSTATE, with a
//               registered (1-cycle) read port. The read register holds its
//               value while i_re is low and is cleared by reset; the array
//               itself is not reset.
//   Ports: clk, rst, i_we/i_waddr/i_wdata (write), i_re/i_raddr (read),
//          o_rdata (registered read data)
// Revision    : 1.0 - initial release
// ============================================================================
module spike_filter_state_ram #(
    parameter int NFILTS = 10,
    parameter int NSTATE = 27
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_we,
    input  wire logic [NFILTS-1:0] i_waddr,
    input  wire logic [NSTATE-1:0] i_wdata,
    input  wire logic              i_re,
    input  wire logic [NFILTS-1:0] i_raddr,
    output logic      [NSTATE-1:0] o_rdata
);
    localparam int c_DEPTH = 2 ** NFILTS;

    logic [NSTATE-1:0] r_mem [0:c_DEPTH-1];
    logic [NSTATE-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;
endmodule : spike_filter_state_ram
`default_nettype wire

// File: rtl/spike_filter_array.sv
`default_nettype none
// ============================================================================
// Module      : spike_filter_array
// Description : Bank of exponentially-decaying spike accumulators, one per
//               filter. Spike-count words add increment*ct (saturating) to
//               the addressed filter; every time-unit pulse sweeps filters
//               0..filts_used, emits each pre-decay state and then scales
//               it by decay_constant (Q0.NSTATE).
//   Ports: clk, reset              - clock, synchronous active-high reset
//          filts_used              - highest filter index in use
//          increment_constant      - amount added per counted spike
//          decay_constant          - Q0.NSTATE decay multiplier
//          time_unit_pulse         - one-cycle sweep strobe
//          bus (slave)             - spike-count input / filter output
//          sweep_overrun           - sticky: a time-unit pulse was lost
// Revision    : 1.0 - initial release
// ============================================================================
module spike_filter_array
    import spike_filter_pkg::*;
#(
    parameter int NFILTS = c_NFILTS,
    parameter int NSTATE = c_NSTATE,
    parameter int NTAG   = c_NTAG,   // must be >= NFILTS
    parameter int NCT    = c_NCT
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic [NFILTS-1:0] filts_used,
    input  wire logic [NSTATE-1:0] increment_constant,
    input  wire logic [NSTATE-1:0] decay_constant,
    input  wire logic              time_unit_pulse,
    spike_filter_array_if.slave    bus,
    output logic                   sweep_overrun
);

    fsm_state_t        r_state;
    logic [NFILTS-1:0] r_clr_addr;
    logic [NFILTS-1:0] r_idx;
    logic [NFILTS-1:0] r_limit;
    logic [NFILTS-1:0] r_upd_addr;
    logic [NCT-1:0]    r_upd_ct;
    logic              r_pending;
    logic              r_overrun;

    logic              w_tag_hi_zero;
    logic [NFILTS-1:0] w_tag_low;
    logic              w_tag_in_range;
    logic              w_sweep_req;
    logic              w_in_ack;
    logic              w_in_xfer;
    logic              w_ram_we;
    logic [NFILTS-1:0] w_ram_waddr;
    logic [NSTATE-1:0] w_ram_wdata;
    logic              w_ram_re;
    logic [NFILTS-1:0] w_ram_raddr;
    logic [NSTATE-1:0] w_rd_data;
    logic [NSTATE-1:0] w_upd_value;
    logic [NSTATE-1:0] w_decay_value;

    // ------------------------------------------------------------------
    // Tag decode: any set bit above the filter index, or an index past
    // filts_used, makes the word a discard.
    // ------------------------------------------------------------------
    generate
        if (NTAG > NFILTS) begin : g_tag_hi
            assign w_tag_hi_zero = (bus.in_tag[NTAG-1:NFILTS] == '0);
        end else begin : g_tag_no_hi
            assign w_tag_hi_zero = 1'b1;
        end
    endgenerate

    assign w_tag_low      = bus.in_tag[NFILTS-1:0];
    assign w_tag_in_range = w_tag_hi_zero && (w_tag_low <= filts_used);

    // A pending or arriving pulse takes IDLE before any spike word, so the
    // input is held off on that cycle.
    assign w_sweep_req = r_pending || time_unit_pulse;
    assign w_in_ack    = (r_state == c_ST_IDLE) && !w_sweep_req;
    assign w_in_xfer   = w_in_ack && bus.in_v;

    // ------------------------------------------------------------------
    // Arithmetic on the RAM read data
    // ------------------------------------------------------------------
    assign w_upd_value = NSTATE'(f_sat_update(64'(w_rd_data),
                                              64'(increment_constant),
                                              64'(r_upd_ct),
                                              NSTATE));

    assign w_decay_value = NSTATE'(f_decay(64'(w_rd_data),
                                           64'(decay_constant),
                                           NSTATE));

    // ------------------------------------------------------------------
    // RAM port control
    // ------------------------------------------------------------------
    always_comb begin
        w_ram_we    = 1'b0;
        w_ram_waddr = r_idx;
        w_ram_wdata = '0;
        w_ram_re    = 1'b0;
        w_ram_raddr = r_idx;
        case (r_state)
            c_ST_CLEAR: begin
                w_ram_we    = 1'b1;
                w_ram_waddr = r_clr_addr;
            end
            c_ST_IDLE: begin
                if (w_in_xfer && w_tag_in_range) begin
                    w_ram_re    = 1'b1;
                    w_ram_raddr = w_tag_low;
                end
            end
            c_ST_UPD: begin
                w_ram_we    = 1'b1;
                w_ram_waddr = r_upd_addr;
                w_ram_wdata = w_upd_value;
            end
            c_ST_SWEEP_RD: begin
                w_ram_re = 1'b1;
            end
            c_ST_SWEEP_OUT: begin
                if (bus.out_a) begin
                    w_ram_we    = 1'b1;
                    w_ram_wdata = w_decay_value;
                end
            end
            default: begin
                w_ram_we = 1'b0;
            end
        endcase
    end

    // A reset arriving mid-update must not commit the half-finished write;
    // CLEAR rewrites every location anyway.
    spike_filter_state_ram #(
        .NFILTS (NFILTS),
        .NSTATE (NSTATE)
    ) u_state_ram (
        .clk     (clk),
        .rst     (reset),
        .i_we    (w_ram_we && !reset),
        .i_waddr (w_ram_waddr),
        .i_wdata (w_ram_wdata),
        .i_re    (w_ram_re),
        .i_raddr (w_ram_raddr),
        .o_rdata (w_rd_data)
    );

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_ST_CLEAR;
            r_clr_addr <= '0;
            r_idx      <= '0;
            r_limit    <= '0;
            r_upd_addr <= '0;
            r_upd_ct   <= '0;
            r_pending  <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            // Only one pulse can be remembered; a second one is lost.
            if (time_unit_pulse && r_pending) begin
                r_overrun <= 1'b1;
            end

            case (r_state)
                c_ST_CLEAR: begin
                    r_clr_addr <= r_clr_addr + NFILTS'(1);
                    if (r_clr_addr == '1) begin
                        r_state <= c_ST_IDLE;
                    end
                    if (time_unit_pulse) begin
                        r_pending <= 1'b1;
                    end
                end
                c_ST_IDLE: begin
                    if (w_sweep_req) begin
                        r_state   <= c_ST_SWEEP_RD;
                        r_idx     <= '0;
                        r_limit   <= filts_used;
                        r_pending <= 1'b0;
                    end else if (w_in_xfer && w_tag_in_range) begin
                        r_state    <= c_ST_UPD;
                        r_upd_addr <= w_tag_low;
                        r_upd_ct   <= bus.in_ct;
                    end
                end
                c_ST_UPD: begin
                    r_state <= c_ST_IDLE;
                    if (time_unit_pulse) begin
                        r_pending <= 1'b1;
                    end
                end
                c_ST_SWEEP_RD: begin
                    r_state <= c_ST_SWEEP_OUT;
                    if (time_unit_pulse) begin
                        r_pending <= 1'b1;
                    end
                end
                c_ST_SWEEP_OUT: begin
                    if (time_unit_pulse) begin
                        r_pending <= 1'b1;
                    end
                    if (bus.out_a) begin
                        if (r_idx == r_limit) begin
                            r_state <= c_ST_IDLE;
                        end else begin
                            r_idx   <= r_idx + NFILTS'(1);
                            r_state <= c_ST_SWEEP_RD;
                        end
                    end
                end
                default: begin
                    r_state <= c_ST_CLEAR;
                end
            endcase
        end
    end

    // The read register holds its data while SWEEP_OUT waits, so the
    // presented state is stable across an output stall.
    assign bus.in_a           = w_in_ack;
    assign bus.out_v          = (r_state == c_ST_SWEEP_OUT);
    assign bus.out_filt_idx   = r_idx;
    assign bus.out_filt_state = w_rd_data;
    assign sweep_overrun      = r_overrun;

endmodule : spike_filter_array
`default_nettype wire

// File: tb/tb_spike_filter_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_spike_filter_array
// Description : Self-checking bench for spike_filter_array. Directed
//               stimulus pushes hand-computed filter outputs into a queue;
//               a monitor pops and compares each accepted output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spike_filter_array;

    localparam int c_NFILTS = 10;
    localparam int c_NSTATE = 27;
    localparam int c_NTAG   = 11;
    localparam int c_NCT    = 9;

    typedef struct {
        logic [c_NFILTS-1:0] idx;
        logic [c_NSTATE-1:0] st;
    } exp_t;

    logic                clk = 1'b0;
    logic                reset;
    logic [c_NFILTS-1:0] filts_used;
    logic [c_NSTATE-1:0] increment_constant;
    logic [c_NSTATE-1:0] decay_constant;
    logic                time_unit_pulse;
    logic                sweep_overrun;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t exp_q[$];

    spike_filter_array_if #(
        .NFILTS (c_NFILTS),
        .NSTATE (c_NSTATE),
        .NTAG   (c_NTAG),
        .NCT    (c_NCT)
    ) bus ();

    spike_filter_array #(
        .NFILTS (c_NFILTS),
        .NSTATE (c_NSTATE),
        .NTAG   (c_NTAG),
        .NCT    (c_NCT)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .filts_used         (filts_used),
        .increment_constant (increment_constant),
        .decay_constant     (decay_constant),
        .time_unit_pulse    (time_unit_pulse),
        .bus                (bus),
        .sweep_overrun      (sweep_overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int idx, input int st);
        exp_t e;
        e.idx = c_NFILTS'(idx);
        e.st  = c_NSTATE'(st);
        exp_q.push_back(e);
    endtask

    task automatic pulse_tick();
        time_unit_pulse = 1'b1;
        tick();
        time_unit_pulse = 1'b0;
    endtask

    // Holds in_v until in_a is seen, bounded; one extra cycle lets UPD finish.
    task automatic wait_ack(input string name);
        int n;
        bit acc;
        n   = 0;
        acc = 1'b0;
        #1;
        while (!acc && n < 3000) begin
            acc = bus.in_a;
            tick();
            n++;
        end
        bus.in_v = 1'b0;
        check(name, 64'(acc), 64'd1);
        tick();
    endtask

    task automatic send_spike(input int tag, input int ct, input string name);
        bus.in_tag = c_NTAG'(tag);
        bus.in_ct  = c_NCT'(ct);
        bus.in_v   = 1'b1;
        wait_ack(name);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            tick();
            n++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
        repeat (2) tick();
    endtask

    // Scoreboard monitor: each accepted output is checked against the queue.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && bus.out_v && bus.out_a) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_out: got idx=%0d state=0x%0h, expected nothing",
                         bus.out_filt_idx, bus.out_filt_state);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("out idx%0d", e.idx),
                      {27'd0, bus.out_filt_idx, bus.out_filt_state},
                      {27'd0, e.idx, e.st});
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        reset              = 1'b1;
        filts_used         = 10'd3;
        increment_constant = 27'd100;
        decay_constant     = 27'd1 << 26;
        time_unit_pulse    = 1'b0;
        bus.in_tag         = '0;
        bus.in_ct          = '0;
        bus.in_v           = 1'b0;
        bus.out_a          = 1'b1;
        repeat (3) tick();

        // Reset state
        check("rst in_a", 64'(bus.in_a), 64'd0);
        check("rst out_v", 64'(bus.out_v), 64'd0);
        check("rst out_idx", 64'(bus.out_filt_idx), 64'd0);
        check("rst out_state", 64'(bus.out_filt_state), 64'd0);
        check("rst overrun", 64'(sweep_overrun), 64'd0);

        // CLEAR occupies 1024 cycles with in_a low
        reset = 1'b0;
        n = 0;
        while (!bus.in_a && n < 2000) begin
            tick();
            n++;
        end
        check("clear cycles", 64'(n), 64'd1024);

        // First sweep after clear: 4 zero outputs, out_v two cycles after pulse
        for (int i = 0; i < 4; i++) push_exp(i, 0);
        pulse_tick();
        check("lat out_v t+1", 64'(bus.out_v), 64'd0);
        tick();
        check("lat out_v t+2", 64'(bus.out_v), 64'd1);
        drain("drain sweep0");

        // Two spikes of ct=3 to tag 5 (inc 100) -> 600, then decay by 0.5
        filts_used = 10'd7;
        send_spike(5, 3, "ack tag5 a");
        send_spike(5, 3, "ack tag5 b");
        for (int i = 0; i < 8; i++) push_exp(i, (i == 5) ? 600 : 0);
        pulse_tick();
        drain("drain sweep1");
        for (int i = 0; i < 8; i++) push_exp(i, (i == 5) ? 300 : 0);
        pulse_tick();
        drain("drain sweep2");

        // Saturation: 2**26 * 4 overflows 27 bits -> clamps to 0x7FFFFFF
        filts_used         = 10'd3;
        increment_constant = 27'd1 << 26;
        send_spike(1, 4, "ack sat");
        for (int i = 0; i < 4; i++) push_exp(i, (i == 1) ? 27'h7FFFFFF : 0);
        pulse_tick();
        drain("drain sat");

        // decay_constant = 0 zeroes swept filters (tag 5 above limit untouched)
        increment_constant = 27'd100;
        decay_constant     = 27'd0;
        for (int i = 0; i < 4; i++) push_exp(i, (i == 1) ? 27'h3FFFFFF : 0);
        pulse_tick();
        drain("drain decay0");
        decay_constant = 27'd1 << 26;

        // Out-of-range tags are acknowledged and discarded
        send_spike(11'h400, 5, "ack tag 0x400");
        send_spike(7, 5, "ack tag 7");
        for (int i = 0; i < 4; i++) push_exp(i, 0);
        pulse_tick();
        drain("drain oor3");
        filts_used = 10'd7;
        for (int i = 0; i < 8; i++) push_exp(i, (i == 5) ? 150 : 0);
        pulse_tick();
        drain("drain oor7");
        check("overrun before stall", 64'(sweep_overrun), 64'd0);

        // Output stall of 10 cycles with two pulses during it
        filts_used = 10'd3;
        bus.out_a  = 1'b0;
        send_spike(0, 1, "ack tag0");
        for (int i = 0; i < 4; i++) push_exp(i, (i == 0) ? 100 : 0);
        for (int i = 0; i < 4; i++) push_exp(i, (i == 0) ? 50 : 0);
        pulse_tick();
        n = 0;
        while (!bus.out_v && n < 20) begin
            tick();
            n++;
        end
        check("stall out_v seen", 64'(bus.out_v), 64'd1);
        for (int i = 0; i < 10; i++) begin
            check("stall out_v", 64'(bus.out_v), 64'd1);
            check("stall idx", 64'(bus.out_filt_idx), 64'd0);
            check("stall state", 64'(bus.out_filt_state), 64'd100);
            if (i == 3 || i == 6) pulse_tick();
            else tick();
        end
        bus.out_a = 1'b1;
        drain("drain stall");
        check("overrun after stall", 64'(sweep_overrun), 64'd1);

        // Spike and pulse in the same IDLE cycle: sweep first, spike after
        bus.in_tag      = 11'd1;
        bus.in_ct       = 9'd2;
        bus.in_v        = 1'b1;
        time_unit_pulse = 1'b1;
        #1;
        check("collide in_a", 64'(bus.in_a), 64'd0);
        for (int i = 0; i < 4; i++) push_exp(i, (i == 0) ? 25 : 0);
        tick();
        time_unit_pulse = 1'b0;
        wait_ack("ack collide");
        drain("drain collide");
        push_exp(0, 12);
        push_exp(1, 200);
        push_exp(2, 0);
        push_exp(3, 0);
        pulse_tick();
        drain("drain after collide");

        check("queue empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_spike_filter_array
`default_nettype wire
